// File: rtl/flappy_pkg.sv
// flappy_pkg: definitions shared by the FlappyBird game-control slice.
//   state_t   - game state encoding (matches the 2-bit state output)
//   BCD_W     - width of one BCD score digit
//   ctr_width - bits needed to hold 0..max_val (never less than 1)
package flappy_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FLY  = 2'd1,
    ST_DEAD = 2'd2,
    ST_HIT  = 2'd3
  } state_t;

  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_sat_counter.sv
// bcd_sat_counter: multi-digit BCD up-counter that sticks at all-9s.
//   clk   - system clock
//   rst   - synchronous active-high reset (value -> 0)
//   clear - synchronous clear (value -> 0), wins over inc
//   inc   - add one, per-digit decimal carry, no wrap past all-9s
//   value - BCD value, LS digit in bits [3:0]
module bcd_sat_counter
  import flappy_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    inc,
  output logic [BCD_W*DIGITS-1:0] value
);

  logic [BCD_W*DIGITS-1:0] r_value;
  logic [BCD_W*DIGITS-1:0] w_next;
  logic                    w_all9;
  logic                    w_carry;

  always_comb begin
    w_next  = r_value;
    w_all9  = 1'b1;
    w_carry = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_value[d*BCD_W +: BCD_W] != 4'd9) w_all9 = 1'b0;
      if (w_carry) begin
        if (r_value[d*BCD_W +: BCD_W] == 4'd9) begin
          w_next[d*BCD_W +: BCD_W] = '0;
        end else begin
          w_next[d*BCD_W +: BCD_W] = r_value[d*BCD_W +: BCD_W] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_value <= '0;
    end else if (inc && !w_all9) begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game-control FSM for the FlappyBird top level.
// Multi-life play, hit/respawn pause, post-respawn invulnerability,
// saturating BCD score and a dead-screen hold. All timing in frames.
//   clk, rst   - clock, synchronous active-high reset
//   frame_tick - one-cycle pulse per video frame
//   flap_req   - flap key pulse
//   pipe_pass  - bird cleared a pipe (pulse)
//   collide    - bird overlaps pipe/ground (level)
//   state      - 0 WAIT, 1 FLY, 2 DEAD, 3 HIT
//   score      - BCD score;  lives - remaining lives
//   flap_out   - flap impulse;  respawn - pulse on HIT->FLY
//   grace      - high while collisions are ignored
//   hi_score   - best score, present only with FLAPPY_HIGH_SCORE_EN
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned GRACE_FRAMES = 90,
  parameter int unsigned DEAD_HOLD    = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic                          flap_req,
  input  logic                          pipe_pass,
  input  logic                          collide,
  output logic [1:0]                    state,
  output logic [BCD_W*SCORE_DIGITS-1:0] score,
  output logic [3:0]                    lives,
  output logic                          flap_out,
  output logic                          respawn,
  output logic                          grace
`ifdef FLAPPY_HIGH_SCORE_EN
  ,
  output logic [BCD_W*SCORE_DIGITS-1:0] hi_score
`endif
);

  localparam int unsigned SW   = BCD_W * SCORE_DIGITS;
  localparam int unsigned TMAX = (HIT_FRAMES > DEAD_HOLD) ? HIT_FRAMES : DEAD_HOLD;
  localparam int unsigned TW   = ctr_width(TMAX);
  localparam int unsigned GW   = ctr_width(GRACE_FRAMES);

  // r_timer serves as the HIT pause counter and the DEAD hold counter;
  // the two states never overlap.
  state_t          r_state,   w_state_nx;
  logic [3:0]      r_lives,   w_lives_nx;
  logic [TW-1:0]   r_timer,   w_timer_nx;
  logic [GW-1:0]   r_grace,   w_grace_nx;
  logic            r_flap,    w_flap_nx;
  logic            r_respawn, w_respawn_nx;
  logic            w_score_clr;
  logic            w_score_inc;
  logic [SW-1:0]   w_score;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_WAIT;
      r_lives   <= 4'(LIVES);
      r_timer   <= '0;
      r_grace   <= '0;
      r_flap    <= 1'b0;
      r_respawn <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lives   <= w_lives_nx;
      r_timer   <= w_timer_nx;
      r_grace   <= w_grace_nx;
      r_flap    <= w_flap_nx;
      r_respawn <= w_respawn_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_lives_nx   = r_lives;
    w_timer_nx   = r_timer;
    w_grace_nx   = r_grace;
    w_flap_nx    = 1'b0;
    w_respawn_nx = 1'b0;
    w_score_clr  = 1'b0;
    w_score_inc  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (flap_req) begin
          w_state_nx  = ST_FLY;
          w_lives_nx  = 4'(LIVES);
          w_grace_nx  = '0;
          w_score_clr = 1'b1;
          w_flap_nx   = 1'b1;
        end
      end
      ST_FLY: begin
        w_flap_nx   = flap_req;
        w_score_inc = pipe_pass;
        if (frame_tick && (r_grace != '0)) w_grace_nx = r_grace - GW'(1);
        // A collision is only processed with grace at zero, so the grace
        // decrement above can never coincide with a state change.
        if (collide && (r_grace == '0)) begin
          if (r_lives == 4'd1) begin
            w_lives_nx = '0;
            w_state_nx = ST_DEAD;
            w_timer_nx = TW'(DEAD_HOLD);
          end else begin
            w_lives_nx = r_lives - 4'd1;
            w_state_nx = ST_HIT;
            w_timer_nx = TW'(HIT_FRAMES);
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (r_timer <= TW'(1)) begin
            w_state_nx   = ST_FLY;
            w_timer_nx   = '0;
            w_respawn_nx = 1'b1;
            w_grace_nx   = GW'(GRACE_FRAMES);
          end else begin
            w_timer_nx = r_timer - TW'(1);
          end
        end
      end
      ST_DEAD: begin
        if (flap_req && (r_timer == '0)) begin
          w_state_nx = ST_WAIT;
        end else if (frame_tick && (r_timer != '0)) begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      default: w_state_nx = ST_WAIT;
    endcase
  end

  bcd_sat_counter #(
    .DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk  (clk),
    .rst  (rst),
    .clear(w_score_clr),
    .inc  (w_score_inc),
    .value(w_score)
  );

  assign state    = r_state;
  assign score    = w_score;
  assign lives    = r_lives;
  assign flap_out = r_flap;
  assign respawn  = r_respawn;
  assign grace    = (r_grace != '0);

`ifdef FLAPPY_HIGH_SCORE_EN
  // Compared on the first cycle spent in DEAD rather than the entry edge,
  // so a pipe_pass landing on the fatal edge is already in the score.
  logic          r_was_dead;
  logic [SW-1:0] r_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_was_dead <= 1'b0;
      r_hi       <= '0;
    end else begin
      r_was_dead <= (r_state == ST_DEAD);
      if ((r_state == ST_DEAD) && !r_was_dead && (w_score > r_hi)) r_hi <= w_score;
    end
  end

  assign hi_score = r_hi;
`endif

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Parametrised game-control FSM for the FlappyBird top level. Replaces the bare 2-bit state / 8-bit score registers held in the top.
- Adds multi-life play, a hit/respawn pause, invulnerability grace, a saturating multi-digit BCD score and a dead-screen hold.
- Sits between the keypad decoder, the display/collision logic and the 7-segment driver.
- All timing is in frames, driven by a one-cycle frame_tick from the VGA timing logic.

Parameters:
- SCORE_DIGITS, 4: number of BCD score digits; score width is 4*SCORE_DIGITS.
- LIVES, 3: lives per game, range 1..15.
- HIT_FRAMES, 60: frames frozen in HIT after a non-fatal collision, must be >= 1.
- GRACE_FRAMES, 90: frames after respawn during which collide is ignored.
- DEAD_HOLD, 30: frames in DEAD before flap_req is accepted.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- frame_tick, in, 1: one-cycle pulse per video frame.
- flap_req, in, 1: one-cycle pulse on the flap key press.
- pipe_pass, in, 1: one-cycle pulse when the bird clears a pipe.
- collide, in, 1: level; bird overlaps a pipe or the ground.
- state, out, 2: 0 WAIT, 1 FLY, 2 DEAD, 3 HIT.
- score, out, 4*SCORE_DIGITS: BCD score, LS digit in bits [3:0].
- lives, out, 4: remaining lives.
- flap_out, out, 1: one-cycle flap impulse to the physics block.
- respawn, out, 1: one-cycle pulse on HIT->FLY; physics resets the bird position.
- grace, out, 1: high while invulnerable; display blinks the bird.
- hi_score, out, 4*SCORE_DIGITS: best score (HIGH_SCORE_EN only).

Behaviour:
- Reset (synchronous, active-high): state=WAIT, score=0, lives=LIVES, all counters=0, flap_out=respawn=grace=0, hi_score=0. A reset mid-game aborts it with no hi_score update.
- All outputs are registered. An input sampled at edge N takes effect at edge N+1.
- WAIT + flap_req:
  - go to FLY, score=0, lives=LIVES, grace counter=0;
  - flap_out pulses 1 cycle.
  - Other inputs are ignored in WAIT.
- FLY + flap_req: flap_out pulses 1 cycle.
- FLY + pipe_pass: score increments as BCD with per-digit carry.
  - Saturates at all-9s; it never wraps to 0.
- FLY + collide while the grace counter is 0:
  - lives decrements;
  - if the pre-decrement value was 1: lives=0, go to DEAD, load the hold counter with DEAD_HOLD;
  - otherwise go to HIT, load the pause counter with HIT_FRAMES.
- FLY + collide while the grace counter is nonzero: ignored.
- HIT:
  - flap_req and pipe_pass are ignored;
  - the pause counter decrements on each frame_tick;
  - on the tick that brings it to 0: go to FLY, respawn pulses, grace counter=GRACE_FRAMES.
- The grace counter decrements on frame_tick while in FLY. grace = (grace counter != 0).
- DEAD:
  - the hold counter decrements on frame_tick down to 0;
  - flap_req with hold==0 returns to WAIT; flap_out does not pulse;
  - flap_req with hold>0 is ignored;
  - score and lives are held for display.
- Simultaneous events in FLY:
  - pipe_pass and collide in the same cycle: the score increments and the collision is also processed;
  - flap_req and a fatal collide in the same cycle: DEAD wins, and flap_out still pulses.
- frame_tick that coincides with a state transition: counters load their new value; there is no decrement that cycle.

Optional Feature:
- Macro: FLAPPY_HIGH_SCORE_EN.
- When defined: on entry to DEAD, hi_score <= score if score > hi_score (unsigned compare; BCD order equals binary order). hi_score is cleared only by rst.
- When undefined: the hi_score port is absent, along with its register and comparator.

Decomposition:
- Shared package flappy_pkg holds:
  - the state encoding constants ST_WAIT, ST_FLY, ST_DEAD, ST_HIT;
  - the BCD digit width constant (4).
- One natural sub-module: bcd_sat_counter, parametrised by DIGITS, with inc, clear and saturate. It is instantiated for the score.

Test Plan:
- Reset, then flap_req -> state=1, lives=3, score=0, flap_out high exactly 1 cycle.
- 12 pipe_pass pulses in FLY -> score=16'h0012. With SCORE_DIGITS=2, 105 pulses -> score=8'h99 (saturated).
- collide in FLY with lives=3 -> state=3, lives=2. After 60 frame_ticks -> state=1, respawn 1 cycle, grace=1. collide during the next 90 ticks is ignored; after that a collide gives lives=1.
- Third fatal collide -> state=2, lives=0. flap_req before 30 ticks is ignored. flap_req after 30 ticks -> state=0.
- pipe_pass and collide on the same edge with score=5, lives=2 -> score=6, state=3, lives=1.
- HIGH_SCORE_EN: game ending at score 7, then a game ending at score 4 -> hi_score=7. rst mid-game -> hi_score=0, state=0.
